// File: rtl/elastic_pipe_stage.sv
// Elastic decode->execute stage register with 2-entry skid buffer.
// Optional perf counters: define PIPE_STAGE_PERF_EN.
module elastic_pipe_stage #(
  parameter int          DW         = 128,
  parameter int          EW         = 5,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_pc,
  input  logic [DW-1:0] in_data,
  input  logic [EW-1:0] in_exc,
  input  logic [EW-1:0] det_exc,
  input  logic          in_bd,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_pc,
  output logic [DW-1:0] out_data,
  output logic [EW-1:0] out_exc,
  output logic          out_bd,
  output logic [1:0]    occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]   perf_stall,
  output logic [31:0]   perf_bubble
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic          push;
  logic          pop;
  logic [EW-1:0] merged_exc;

  logic [31:0]   skid_pc;
  logic [DW-1:0] skid_data;
  logic [EW-1:0] skid_exc;
  logic          skid_bd;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // upstream code wins over the one found here
  assign merged_exc = (in_exc != '0) ? in_exc : det_exc;

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // next state: flush beats any handshake
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (push) state_nxt = ONE;
        ONE: begin
          if (push && !pop) state_nxt = FULL;
          else if (!push && pop) state_nxt = EMPTY;
        end
        FULL: if (pop) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // status outputs decoded from registered state only
  always_comb begin
    out_valid = 1'b0;
    in_ready  = 1'b1;
    occupancy = 2'd0;
    unique case (state)
      EMPTY: begin
        out_valid = 1'b0;
      end
      ONE: begin
        out_valid = 1'b1;
        occupancy = 2'd1;
      end
      FULL: begin
        out_valid = 1'b1;
        in_ready  = 1'b0;
        occupancy = 2'd2;
      end
      default: begin
        out_valid = 1'b0;
      end
    endcase
  end

  // head register; pc/bd survive a bubble for EPC/BD
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_pc   <= RESET_PC;
      out_data <= '0;
      out_exc  <= '0;
      out_bd   <= 1'b0;
    end else if (flush) begin
      out_pc   <= HANDLER_PC;
      out_data <= '0;
      out_exc  <= '0;
      out_bd   <= 1'b0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (push) begin
            out_pc   <= in_pc;
            out_data <= in_data;
            out_exc  <= merged_exc;
            out_bd   <= in_bd;
          end
        end
        ONE: begin
          if (push && pop) begin
            out_pc   <= in_pc;
            out_data <= in_data;
            out_exc  <= merged_exc;
            out_bd   <= in_bd;
          end else if (!push && pop) begin
            out_data <= '0;
            out_exc  <= '0;
          end
        end
        FULL: begin
          if (pop) begin
            out_pc   <= skid_pc;
            out_data <= skid_data;
            out_exc  <= skid_exc;
            out_bd   <= skid_bd;
          end
        end
        default: begin
          out_data <= '0;
          out_exc  <= '0;
        end
      endcase
    end
  end

  // skid register catches the entry arriving under backpressure
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skid_pc   <= '0;
      skid_data <= '0;
      skid_exc  <= '0;
      skid_bd   <= 1'b0;
    end else if (!flush && state == ONE && push && !pop) begin
      skid_pc   <= in_pc;
      skid_data <= in_data;
      skid_exc  <= merged_exc;
      skid_bd   <= in_bd;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  // free-running stall/bubble counters, immune to flush
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall  <= '0;
      perf_bubble <= '0;
    end else begin
      if (in_valid && !in_ready) perf_stall <= perf_stall + 32'd1;
      if (!out_valid && out_ready) perf_bubble <= perf_bubble + 32'd1;
    end
  end
`endif

endmodule
